// File: rtl/vga_timing.sv
// VGA raster timing: pixel clock-enable, syncs, active-video flag and x/y counters.
// Every output is registered and decoded from the next-state counters, so they all describe the same pixel.
module vga_timing #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CLK_DIV   = 2,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic        input_clk,
   input  logic        reset,
   output logic        pix_ce,
   output logic        hsync,
   output logic        vsync,
   output logic        active,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        line_start,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS   = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS   = 11'(V_ACTIVE);
   localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0]  div;
   logic        tick;
   logic [10:0] x_nxt;
   logic [10:0] y_nxt;

   assign tick = (div == DIV_LAST);

   always_comb begin
      x_nxt = x;
      y_nxt = y;
      if (tick) begin
         if (x == H_LAST) begin
            x_nxt = 11'd0;
            y_nxt = (y == V_LAST) ? 11'd0 : y + 11'd1;
         end else begin
            x_nxt = x + 11'd1;
         end
      end
   end

   // Reset parks the counters on the last back-porch pixel so the first tick lands on (0,0).
   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         div         <= 4'd0;
         x           <= H_LAST;
         y           <= V_LAST;
         pix_ce      <= 1'b0;
         active      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
      end else begin
         div         <= tick ? 4'd0 : div + 4'd1;
         x           <= x_nxt;
         y           <= y_nxt;
         pix_ce      <= tick;
         active      <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
         line_start  <= (x_nxt == 11'd0);
         frame_start <= (x_nxt == 11'd0) && (y_nxt == 11'd0);
         hsync       <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? VSYNC_POL : ~VSYNC_POL;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three configurations checked against a pixel-count reference model.
module tb_vga_timing;

   typedef struct packed {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp, div;
      bit hpol, vpol;
   } cfg_t;

   typedef struct packed {
      logic [10:0] x, y;
      logic act, hs, vs, ls, fs, ce;
   } exp_t;

   localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
   localparam cfg_t C_MED = '{20, 3, 5, 4, 10, 2, 3, 2, 3, 1'b1, 1'b0};
   localparam cfg_t C_ONE = '{4, 1, 1, 1, 4, 1, 1, 1, 1, 1'b0, 1'b1};

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // rising edges since reset release
   int n;
   always @(posedge clk or posedge reset)
      if (reset) n <= 0;
      else       n <= n + 1;

   int checks = 0;
   int fails  = 0;

   logic        d_ce, d_hs, d_vs, d_act, d_ls, d_fs;
   logic [10:0] d_x, d_y;
   logic        m_ce, m_hs, m_vs, m_act, m_ls, m_fs;
   logic [10:0] m_x, m_y;
   logic        o_ce, o_hs, o_vs, o_act, o_ls, o_fs;
   logic [10:0] o_x, o_y;

   vga_timing u_def (
      .input_clk(clk), .reset(reset), .pix_ce(d_ce), .hsync(d_hs), .vsync(d_vs),
      .active(d_act), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs));

   vga_timing #(
      .H_ACTIVE(C_MED.ha), .H_FP(C_MED.hfp), .H_SYNC(C_MED.hs), .H_BP(C_MED.hbp),
      .V_ACTIVE(C_MED.va), .V_FP(C_MED.vfp), .V_SYNC(C_MED.vs), .V_BP(C_MED.vbp),
      .CLK_DIV(C_MED.div), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
   ) u_med (
      .input_clk(clk), .reset(reset), .pix_ce(m_ce), .hsync(m_hs), .vsync(m_vs),
      .active(m_act), .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs));

   vga_timing #(
      .H_ACTIVE(C_ONE.ha), .H_FP(C_ONE.hfp), .H_SYNC(C_ONE.hs), .H_BP(C_ONE.hbp),
      .V_ACTIVE(C_ONE.va), .V_FP(C_ONE.vfp), .V_SYNC(C_ONE.vs), .V_BP(C_ONE.vbp),
      .CLK_DIV(C_ONE.div), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
   ) u_one (
      .input_clk(clk), .reset(reset), .pix_ce(o_ce), .hsync(o_hs), .vsync(o_vs),
      .active(o_act), .x(o_x), .y(o_y), .line_start(o_ls), .frame_start(o_fs));

   // Expected outputs after k rising edges out of reset: k/div pixel updates along the raster.
   function automatic exp_t model(cfg_t c, int k);
      int ht, vt, u, p, px, py;
      exp_t e;
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      u  = k / c.div;
      if (u == 0) begin
         e = '{11'(ht - 1), 11'(vt - 1), 1'b0, ~c.hpol, ~c.vpol, 1'b0, 1'b0, 1'b0};
      end else begin
         p  = (u - 1) % (ht * vt);
         px = p % ht;
         py = p / ht;
         e.x   = 11'(px);
         e.y   = 11'(py);
         e.act = (px < c.ha) && (py < c.va);
         e.hs  = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
         e.vs  = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
         e.ls  = (px == 0);
         e.fs  = (px == 0) && (py == 0);
         e.ce  = (k % c.div == 0);
      end
      return e;
   endfunction

   function automatic cfg_t cfg(int i);
      case (i)
         0:       return C_DEF;
         1:       return C_MED;
         default: return C_ONE;
      endcase
   endfunction

   function automatic exp_t obs(int i);
      case (i)
         0:       return '{d_x, d_y, d_act, d_hs, d_vs, d_ls, d_fs, d_ce};
         1:       return '{m_x, m_y, m_act, m_hs, m_vs, m_ls, m_fs, m_ce};
         default: return '{o_x, o_y, o_act, o_hs, o_vs, o_ls, o_fs, o_ce};
      endcase
   endfunction

   task automatic test_reset();
      exp_t got, exp;
      reset = 1'b1;
      repeat (5 + $urandom_range(0, 3)) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         got = obs(i); exp = model(cfg(i), 0);
         checks++;
         if (got !== exp) begin
            fails++;
            $display("FAIL reset_state inst%0d got=%p exp=%p", i, got, exp);
         end
      end
      checks++;
      if (d_x !== 11'd799 || d_y !== 11'd524) begin
         fails++;
         $display("FAIL reset_xy got=%0d,%0d exp=799,524", d_x, d_y);
      end
   endtask

   task automatic test_first_pixel();
      exp_t got, exp;
      @(negedge clk) reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            got = obs(i); exp = model(cfg(i), n);
            checks++;
            if (got !== exp) begin
               fails++;
               $display("FAIL first_pixel inst%0d edge%0d got=%p exp=%p", i, k, got, exp);
            end
         end
         if (k == 2) begin
            checks++;
            if ({d_x, d_y, d_fs, d_ce} !== {11'd0, 11'd0, 1'b1, 1'b1}) begin
               fails++;
               $display("FAIL first_pixel_def got x=%0d y=%0d fs=%b ce=%b exp 0 0 1 1", d_x, d_y, d_fs, d_ce);
            end
         end
         if (k == 3) begin
            checks++;
            if ({d_x, d_fs, d_ce} !== {11'd0, 1'b1, 1'b0}) begin
               fails++;
               $display("FAIL hold_def got x=%0d fs=%b ce=%b exp 0 1 0", d_x, d_fs, d_ce);
            end
         end
      end
   endtask

   task automatic test_horizontal();
      exp_t got, exp;
      int last_rise = -1;
      logic prev_ls, prev_hs, prev_act;
      prev_ls = d_ls; prev_hs = d_hs; prev_act = d_act;
      repeat (2 * 1600 + 100) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            got = obs(i); exp = model(cfg(i), n);
            checks++;
            if (got !== exp) begin
               fails++;
               $display("FAIL horiz_model inst%0d n=%0d got=%p exp=%p", i, n, got, exp);
            end
         end
         if (d_ls && !prev_ls) begin
            if (last_rise >= 0) begin
               checks++;
               if (n - last_rise !== 1600) begin
                  fails++;
                  $display("FAIL line_period got=%0d exp=1600", n - last_rise);
               end
            end
            last_rise = n;
         end
         if (d_hs !== prev_hs) begin
            checks++;
            if (d_x !== (d_hs ? 11'd752 : 11'd656)) begin
               fails++;
               $display("FAIL hsync_edge hs=%b got x=%0d exp %0d", d_hs, d_x, d_hs ? 752 : 656);
            end
         end
         if (prev_act && !d_act) begin
            checks++;
            if (d_x !== 11'd640) begin
               fails++;
               $display("FAIL active_fall got x=%0d exp 640", d_x);
            end
         end
         prev_ls = d_ls; prev_hs = d_hs; prev_act = d_act;
      end
   endtask

   task automatic test_vertical();
      exp_t got, exp;
      int last_rise = -1;
      int vs_low = 0;
      int frame = 32 * 17 * 3;
      logic prev_fs, prev_vs;
      prev_fs = m_fs; prev_vs = m_vs;
      repeat (2 * frame + 50) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            got = obs(i); exp = model(cfg(i), n);
            checks++;
            if (got !== exp) begin
               fails++;
               $display("FAIL vert_model inst%0d n=%0d got=%p exp=%p", i, n, got, exp);
            end
         end
         if (m_fs && !prev_fs) begin
            if (last_rise >= 0) begin
               checks++;
               if (n - last_rise !== frame) begin
                  fails++;
                  $display("FAIL frame_period got=%0d exp=%0d", n - last_rise, frame);
               end
            end
            last_rise = n;
         end
         if (m_vs !== prev_vs) begin
            checks++;
            if (m_x !== 11'd0) begin
               fails++;
               $display("FAIL vsync_at_wrap got x=%0d exp 0", m_x);
            end
            if (m_vs) begin
               checks++;
               if (vs_low !== 3 * 32 * 3) begin
                  fails++;
                  $display("FAIL vsync_width got=%0d exp=%0d", vs_low, 3 * 32 * 3);
               end
            end
            vs_low = 0;
         end
         if (!m_vs) vs_low++;
         prev_fs = m_fs; prev_vs = m_vs;
      end
   endtask

   task automatic test_clkdiv1();
      exp_t got, exp;
      repeat (120) begin
         @(negedge clk);
         got = obs(2); exp = model(C_ONE, n);
         checks++;
         if (got !== exp || o_ce !== 1'b1) begin
            fails++;
            $display("FAIL clkdiv1 n=%0d got=%p exp=%p", n, got, exp);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t got, exp;
      int k;
      repeat (2) begin
         repeat ($urandom_range(50, 1500)) @(negedge clk);
         #2 reset = 1'b1;
         #1;
         for (int i = 0; i < 3; i++) begin
            got = obs(i); exp = model(cfg(i), 0);
            checks++;
            if (got !== exp) begin
               fails++;
               $display("FAIL mid_reset inst%0d got=%p exp=%p", i, got, exp);
            end
         end
         repeat ($urandom_range(1, 4)) @(negedge clk);
         reset = 1'b0;
         k = 0;
         do begin
            @(negedge clk);
            k++;
            for (int i = 0; i < 3; i++) begin
               got = obs(i); exp = model(cfg(i), n);
               checks++;
               if (got !== exp) begin
                  fails++;
                  $display("FAIL restart inst%0d n=%0d got=%p exp=%p", i, n, got, exp);
               end
            end
         end while (!m_fs && k < 20);
         checks++;
         if (k !== C_MED.div) begin
            fails++;
            $display("FAIL restart_latency got=%0d exp=%0d", k, C_MED.div);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_pixel();
      test_horizontal();
      test_vertical();
      test_clkdiv1();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
